// File: rtl/sr_input_conditioner.sv
// Conditions raw set/reset/enable board inputs into clean registered S/R/EN drive
// for a gated SR latch: synchronise, debounce, arbitrate, and optionally one-shot.
//
// state  | meaning
// IDLE   | waiting for a fresh, enabled set or reset press
// PULSE  | EN driven high with the latched command, pulse timer running
// HOLD   | outputs low until both buttons are released

module sr_input_conditioner #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int EN_PULSE_CYCLES = 4,
    parameter int PULSE_MODE      = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_set,
    input  logic btn_reset,
    input  logic sw_en,
    output logic s_out,
    output logic r_out,
    output logic en_out,
    output logic illegal,
    output logic busy
);

    localparam int CH     = 3;
    localparam int CH_SET = 0;
    localparam int CH_RST = 1;
    localparam int CH_EN  = 2;
    localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES);
    localparam int PCNT_W = (EN_PULSE_CYCLES > 1) ? $clog2(EN_PULSE_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [PCNT_W-1:0] PCNT_LOAD = PCNT_W'(EN_PULSE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    logic [CH-1:0]                  raw;
    logic [CH-1:0][SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CH-1:0]                  db_q, db_d;
    logic [CH-1:0][CNT_W-1:0]       cnt_q, cnt_d;

    state_t              state_q, state_d;
    logic [PCNT_W-1:0]   pcnt_q, pcnt_d;
    logic                cmd_set_q, cmd_set_d;
    logic                s_req_prev_q, s_req_prev_d;
    logic                r_req_prev_q, r_req_prev_d;
    logic                s_out_q, s_out_d;
    logic                r_out_q, r_out_d;
    logic                en_out_q, en_out_d;
    logic                illegal_q, illegal_d;

    logic db_set, db_reset, db_en;
    logic s_req, r_req, both_req;
    logic s_rise, r_rise, abort;

    assign raw = {sw_en, btn_reset, btn_set};

    // Debounce: a new level is accepted only after DEBOUNCE_CYCLES consecutive
    // synchronised samples that disagree with the current accepted level.
    always_comb begin
        sync_d = '0;
        db_d   = db_q;
        cnt_d  = '0;
        for (int i = 0; i < CH; i++) begin
            sync_d[i] = {sync_q[i][SYNC_STAGES-2:0], raw[i]};
            if (sync_q[i][SYNC_STAGES-1] != db_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    db_d[i] = sync_q[i][SYNC_STAGES-1];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    assign db_set   = db_q[CH_SET];
    assign db_reset = db_q[CH_RST];
    assign db_en    = db_q[CH_EN];

    assign s_req    = db_set & ~db_reset;
    assign r_req    = db_reset & ~db_set;
    assign both_req = db_set & db_reset;
    assign s_rise   = s_req & ~s_req_prev_q;
    assign r_rise   = r_req & ~r_req_prev_q;
    assign abort    = both_req | ~db_en;

    always_comb begin
        state_d      = state_q;
        pcnt_d       = pcnt_q;
        cmd_set_d    = cmd_set_q;
        s_req_prev_d = s_req;
        r_req_prev_d = r_req;
        s_out_d      = 1'b0;
        r_out_d      = 1'b0;
        en_out_d     = 1'b0;
        illegal_d    = both_req;

        if (PULSE_MODE == 0) begin
            state_d  = ST_IDLE;
            s_out_d  = s_req;
            r_out_d  = r_req;
            en_out_d = db_en;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (db_en && (s_rise || r_rise)) begin
                        cmd_set_d = s_rise;
                        pcnt_d    = PCNT_LOAD;
                        state_d   = ST_PULSE;
                    end
                end
                ST_PULSE: begin
                    // Outputs are registered from the current state, so an abort
                    // must suppress them here to drop them on the very next edge.
                    if (abort) begin
                        state_d = ST_HOLD;
                    end else begin
                        en_out_d = 1'b1;
                        s_out_d  = cmd_set_q;
                        r_out_d  = ~cmd_set_q;
                        if (pcnt_q == '0) begin
                            state_d = ST_HOLD;
                        end else begin
                            pcnt_d = pcnt_q - PCNT_W'(1);
                        end
                    end
                end
                ST_HOLD: begin
                    if (!db_set && !db_reset) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q       <= '0;
            db_q         <= '0;
            cnt_q        <= '0;
            state_q      <= ST_IDLE;
            pcnt_q       <= '0;
            cmd_set_q    <= 1'b0;
            s_req_prev_q <= 1'b0;
            r_req_prev_q <= 1'b0;
            s_out_q      <= 1'b0;
            r_out_q      <= 1'b0;
            en_out_q     <= 1'b0;
            illegal_q    <= 1'b0;
        end else begin
            sync_q       <= sync_d;
            db_q         <= db_d;
            cnt_q        <= cnt_d;
            state_q      <= state_d;
            pcnt_q       <= pcnt_d;
            cmd_set_q    <= cmd_set_d;
            s_req_prev_q <= s_req_prev_d;
            r_req_prev_q <= r_req_prev_d;
            s_out_q      <= s_out_d;
            r_out_q      <= r_out_d;
            en_out_q     <= en_out_d;
            illegal_q    <= illegal_d;
        end
    end

    assign s_out   = s_out_q;
    assign r_out   = r_out_q;
    assign en_out  = en_out_q;
    assign illegal = illegal_q;
    assign busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sr_input_conditioner.sv
// Bench for sr_input_conditioner: a pulse-mode and a level-mode instance share the
// inputs and are compared every cycle against a sample-history reference model.

module tb_sr_input_conditioner;

    localparam int SYNC = 2;
    localparam int DBC  = 4;
    localparam int EPC  = 3;
    localparam int HLEN = SYNC + DBC;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic btn_set = 1'b0, btn_reset = 1'b0, sw_en = 1'b0;
    logic p_s, p_r, p_en, p_ill, p_busy;
    logic l_s, l_r, l_en, l_ill, l_busy;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    sr_input_conditioner #(.SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DBC),
                           .EN_PULSE_CYCLES(EPC), .PULSE_MODE(1)) dut_pulse (
        .clk(clk), .rst_n(rst_n), .btn_set(btn_set), .btn_reset(btn_reset),
        .sw_en(sw_en), .s_out(p_s), .r_out(p_r), .en_out(p_en),
        .illegal(p_ill), .busy(p_busy));

    sr_input_conditioner #(.SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DBC),
                           .EN_PULSE_CYCLES(EPC), .PULSE_MODE(0)) dut_level (
        .clk(clk), .rst_n(rst_n), .btn_set(btn_set), .btn_reset(btn_reset),
        .sw_en(sw_en), .s_out(l_s), .r_out(l_r), .en_out(l_en),
        .illegal(l_ill), .busy(l_busy));

    // Reference model: raw sample history, command timer and release flag.
    bit hist [3][HLEN];
    bit m_db [3];
    int m_left;
    bit m_await, m_cmd_set, m_prev_s, m_prev_r;
    bit e_s, e_r, e_en, e_ill, e_busy;
    bit el_s, el_r, el_en;

    task automatic model_reset();
        for (int c = 0; c < 3; c++) begin
            m_db[c] = 1'b0;
            for (int j = 0; j < HLEN; j++) hist[c][j] = 1'b0;
        end
        m_left = 0; m_await = 1'b0; m_cmd_set = 1'b0;
        m_prev_s = 1'b0; m_prev_r = 1'b0;
        {e_s, e_r, e_en, e_ill, e_busy} = '0;
        {el_s, el_r, el_en} = '0;
    endtask

    task automatic model_step();
        bit raw [3];
        bit ds, dr, de, sreq, rreq, both, stable;
        raw = '{btn_set, btn_reset, sw_en};
        for (int c = 0; c < 3; c++) begin
            for (int j = HLEN - 1; j > 0; j--) hist[c][j] = hist[c][j-1];
            hist[c][0] = raw[c];
        end
        ds = m_db[0]; dr = m_db[1]; de = m_db[2];
        sreq = ds && !dr;
        rreq = dr && !ds;
        both = ds && dr;
        el_s = sreq; el_r = rreq; el_en = de;
        e_ill = both;
        e_s = 1'b0; e_r = 1'b0; e_en = 1'b0;
        if (m_left > 0) begin
            if (both || !de) begin
                m_left = 0;
                m_await = 1'b1;
            end else begin
                e_en = 1'b1;
                e_s = m_cmd_set;
                e_r = !m_cmd_set;
                m_left--;
                if (m_left == 0) m_await = 1'b1;
            end
        end else if (m_await) begin
            if (!ds && !dr) m_await = 1'b0;
        end else if (de && ((sreq && !m_prev_s) || (rreq && !m_prev_r))) begin
            m_left = EPC;
            m_cmd_set = sreq && !m_prev_s;
        end
        m_prev_s = sreq;
        m_prev_r = rreq;
        e_busy = (m_left > 0) || m_await;
        // A level is accepted once the last DBC synchronised samples all agree on it.
        for (int c = 0; c < 3; c++) begin
            stable = 1'b1;
            for (int j = SYNC; j < HLEN; j++)
                if (hist[c][j] != hist[c][SYNC]) stable = 1'b0;
            if (stable && hist[c][SYNC] != m_db[c]) m_db[c] = hist[c][SYNC];
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    task automatic cmp(input string name, input logic [4:0] act, input logic [4:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b expected %b (s,r,en,illegal,busy) at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp_int(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            cmp("pulse_vs_model", {p_s, p_r, p_en, p_ill, p_busy}, {e_s, e_r, e_en, e_ill, e_busy});
            cmp("level_vs_model", {l_s, l_r, l_en, l_ill, l_busy}, {el_s, el_r, el_en, e_ill, 1'b0});
            cmp("s_and_r_never", {3'b000, p_s & p_r, l_s & l_r}, 5'b00000);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    typedef struct {
        logic       set;
        logic       rst;
        logic       en;
        int         cyc;
        logic [4:0] p_exp;
        logic [3:0] l_exp;
    } vec_t;

    vec_t tbl [9];

    initial begin
        int first, wid, bad;
        bit found;

        tbl[0] = '{1'b0, 1'b0, 1'b0, 10, 5'b00000, 4'b0000};
        tbl[1] = '{1'b0, 1'b0, 1'b1, 10, 5'b00000, 4'b0010};
        tbl[2] = '{1'b1, 1'b0, 1'b1, 20, 5'b00001, 4'b1010};
        tbl[3] = '{1'b0, 1'b0, 1'b1, 10, 5'b00000, 4'b0010};
        tbl[4] = '{1'b1, 1'b1, 1'b1, 20, 5'b00010, 4'b0011};
        tbl[5] = '{1'b0, 1'b0, 1'b1, 10, 5'b00000, 4'b0010};
        tbl[6] = '{1'b0, 1'b1, 1'b1, 20, 5'b00001, 4'b0110};
        tbl[7] = '{1'b0, 1'b1, 1'b0, 10, 5'b00001, 4'b0100};
        tbl[8] = '{1'b0, 1'b0, 1'b0, 10, 5'b00000, 4'b0000};

        // Reset held while the inputs toggle.
        for (int k = 0; k < 10; k++) begin
            btn_set = 1'($urandom); btn_reset = 1'($urandom); sw_en = 1'($urandom);
            @(negedge clk);
            cmp("reset_pulse", {p_s, p_r, p_en, p_ill, p_busy}, 5'b00000);
            cmp("reset_level", {l_s, l_r, l_en, l_ill, l_busy}, 5'b00000);
        end
        btn_set = 1'b0; btn_reset = 1'b0; sw_en = 1'b0;
        rst_n = 1'b1;
        tick(10);
        cmp("post_reset", {p_s, p_r, p_en, p_ill, p_busy}, 5'b00000);

        for (int i = 0; i < 9; i++) begin
            btn_set = tbl[i].set; btn_reset = tbl[i].rst; sw_en = tbl[i].en;
            tick(tbl[i].cyc);
            cmp($sformatf("table_pulse_%0d", i), {p_s, p_r, p_en, p_ill, p_busy}, tbl[i].p_exp);
            cmp($sformatf("table_level_%0d", i), {1'b0, l_s, l_r, l_en, l_ill}, {1'b0, tbl[i].l_exp});
        end

        // Held set button: one EN window of EPC cycles, two cycles after the db edge.
        sw_en = 1'b1;
        tick(10);
        btn_set = 1'b1;
        first = -1; wid = 0; bad = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (p_en) begin
                wid++;
                if (first < 0) first = k;
                if (!p_s || p_r) bad++;
            end
        end
        cmp_int("set_pulse_width", wid, 3);
        cmp_int("set_pulse_start", first, 8);
        cmp_int("set_pulse_polarity", bad, 0);
        cmp("set_hold_busy", {p_s, p_r, p_en, p_busy}, 5'b00001);
        btn_set = 1'b0;
        tick(10);
        cmp("set_released_idle", {p_s, p_r, p_en, p_busy}, 5'b00000);

        // Bouncing reset button, then steady.
        first = -1; wid = 0; bad = 0;
        for (int k = 1; k <= 25; k++) begin
            btn_reset = (k <= 6) ? ((k % 2) == 1) : 1'b1;
            @(negedge clk);
            if (p_en) begin
                wid++;
                if (first < 0) first = k;
                if (!p_r || p_s) bad++;
            end
        end
        cmp_int("bounce_pulse_width", wid, 3);
        cmp_int("bounce_pulse_start", first, 14);
        cmp_int("bounce_pulse_polarity", bad, 0);
        btn_reset = 1'b0;
        tick(10);

        // Reset button arriving mid-pulse aborts the set command.
        wid = 0; bad = 0; first = -1;
        btn_set = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            btn_reset = (k >= 3);
            @(negedge clk);
            if (p_en) wid++;
            if (p_s && p_r) bad++;
            if (k == 9) first = int'(p_ill);
        end
        cmp_int("abort_en_cycles", wid, 1);
        cmp_int("abort_illegal", first, 1);
        cmp_int("abort_overlap", bad, 0);
        cmp("abort_hold", {p_s, p_r, p_en, p_ill, p_busy}, 5'b00011);
        btn_set = 1'b0; btn_reset = 1'b0;
        tick(10);

        // Disabled press gives nothing; then reset asserted in the middle of a pulse.
        sw_en = 1'b0;
        tick(10);
        btn_set = 1'b1;
        wid = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (p_en || p_s || p_r) wid++;
        end
        cmp_int("disabled_no_pulse", wid, 0);
        btn_set = 1'b0;
        sw_en = 1'b1;
        tick(10);
        btn_set = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 30 && !found; k++) begin
            @(negedge clk);
            if (p_en) found = 1'b1;
        end
        cmp_int("pulse_seen_before_reset", int'(found), 1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 cmp("async_reset_drop", {p_s, p_r, p_en, p_ill, p_busy}, 5'b00000);
        btn_set = 1'b0; sw_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick(5);
        cmp("idle_after_reset", {p_s, p_r, p_en, p_ill, p_busy}, 5'b00000);

        // Random press patterns, including short glitches, checked by the model.
        for (int seg = 0; seg < 70; seg++) begin
            btn_set   = ($urandom_range(0, 2) == 0);
            btn_reset = ($urandom_range(0, 3) == 0);
            sw_en     = ($urandom_range(0, 5) != 0);
            tick($urandom_range(1, 12));
        end
        btn_set = 1'b0; btn_reset = 1'b0; sw_en = 1'b0;
        tick(12);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
